// File: rtl/para2ser_stream.sv
// Parallel-to-serial driver for shift-register peripheral chains.
// Outputs are registered decodes of the next state, so seg_clk is never derived from clk.
module para2ser_stream #(
    parameter int unsigned WIDTH       = 24,
    parameter int unsigned CLK_DIV     = 1,
    parameter bit          MSB_FIRST   = 1'b1,
    parameter bit          AUTO_UPDATE = 1'b1,
    parameter bit          CLR_PULSE   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [3:0]       sout
);

    localparam int unsigned BitW = $clog2(WIDTH + 1);
    localparam int unsigned DivW = $clog2(2 * CLK_DIV);
    localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);
    localparam logic [DivW-1:0] LastDiv = DivW'(2 * CLK_DIV - 1);
    localparam logic [DivW-1:0] HalfDiv = DivW'(CLK_DIV);

    typedef enum logic [1:0] {StIdle, StClear, StShift, StFinish} state_e;

    state_e           r_state,     w_state_nxt;
    logic [WIDTH-1:0] r_shreg,     w_shreg_nxt;
    logic [WIDTH-1:0] r_last_sent, w_last_sent_nxt;
    logic             r_pending,   w_pending_nxt;
    logic [DivW-1:0]  r_div,       w_div_nxt;
    logic [BitW-1:0]  r_bit,       w_bit_nxt;
    logic             r_busy,      w_busy_nxt;
    logic             r_done,      w_done_nxt;
    logic             r_seg_clk,   w_seg_clk_nxt;
    logic             r_seg_clr,   w_seg_clr_nxt;
    logic             r_seg_dt,    w_seg_dt_nxt;
    logic             r_seg_en;
    logic             w_trigger;

    always_comb begin
        w_trigger       = r_pending | load | (AUTO_UPDATE && (data != r_last_sent));
        w_state_nxt     = r_state;
        w_shreg_nxt     = r_shreg;
        w_last_sent_nxt = r_last_sent;
        w_pending_nxt   = r_pending | load;
        w_div_nxt       = r_div;
        w_bit_nxt       = r_bit;

        unique case (r_state)
            StIdle: begin
                if (w_trigger) begin
                    w_shreg_nxt     = data;
                    w_last_sent_nxt = data;
                    w_pending_nxt   = 1'b0;
                    w_div_nxt       = '0;
                    w_bit_nxt       = '0;
                    w_state_nxt     = CLR_PULSE ? StClear : StShift;
                end
            end
            StClear: begin
                if (r_div == LastDiv) begin
                    w_div_nxt   = '0;
                    w_state_nxt = StShift;
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            StShift: begin
                if (r_div == LastDiv) begin
                    w_div_nxt   = '0;
                    w_shreg_nxt = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
                    if (r_bit == LastBit) begin
                        w_bit_nxt   = '0;
                        w_state_nxt = StFinish;
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end else begin
                    w_div_nxt = r_div + 1'b1;
                end
            end
            StFinish: begin
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Pin values are decoded from the upcoming state so they line up with it after the edge.
        w_busy_nxt    = (w_state_nxt != StIdle);
        w_done_nxt    = (w_state_nxt == StFinish);
        w_seg_clr_nxt = (w_state_nxt != StClear);
        w_seg_clk_nxt = (w_state_nxt == StShift) && (w_div_nxt >= HalfDiv);
        w_seg_dt_nxt  = 1'b0;
        if (w_state_nxt == StShift) begin
            w_seg_dt_nxt = MSB_FIRST ? w_shreg_nxt[WIDTH-1] : w_shreg_nxt[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_shreg     <= '0;
            r_last_sent <= '0;
            r_pending   <= 1'b1;
            r_div       <= '0;
            r_bit       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_seg_clk   <= 1'b0;
            r_seg_clr   <= 1'b1;
            r_seg_dt    <= 1'b0;
            r_seg_en    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_shreg     <= w_shreg_nxt;
            r_last_sent <= w_last_sent_nxt;
            r_pending   <= w_pending_nxt;
            r_div       <= w_div_nxt;
            r_bit       <= w_bit_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_seg_clk   <= w_seg_clk_nxt;
            r_seg_clr   <= w_seg_clr_nxt;
            r_seg_dt    <= w_seg_dt_nxt;
            r_seg_en    <= 1'b1;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sout = {r_seg_clk, r_seg_clr, r_seg_dt, r_seg_en};

endmodule

// File: tb/tb_para2ser_stream.sv
// Directed bench for para2ser_stream: four instances cover bit order, divider,
// manual-load-only and clear-pulse configurations.
module tb_para2ser_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1, rst_d = 1'b1;
    logic [7:0] data_a = 8'h00, data_b = 8'h00, data_c = 8'h00, data_d = 8'h00;
    logic       load_a = 1'b0, load_b = 1'b0, load_c = 1'b0, load_d = 1'b0;
    logic       busy_a, busy_b, busy_c, busy_d;
    logic       done_a, done_b, done_c, done_d;
    logic [3:0] sout_a, sout_b, sout_c, sout_d;

    para2ser_stream #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b1), .AUTO_UPDATE(1'b1),
                      .CLR_PULSE(1'b0)) u_a (
        .clk(clk), .rst(rst_a), .data(data_a), .load(load_a),
        .busy(busy_a), .done(done_a), .sout(sout_a));
    para2ser_stream #(.WIDTH(8), .CLK_DIV(1), .MSB_FIRST(1'b0), .AUTO_UPDATE(1'b1),
                      .CLR_PULSE(1'b0)) u_b (
        .clk(clk), .rst(rst_b), .data(data_b), .load(load_b),
        .busy(busy_b), .done(done_b), .sout(sout_b));
    para2ser_stream #(.WIDTH(8), .CLK_DIV(3), .MSB_FIRST(1'b1), .AUTO_UPDATE(1'b0),
                      .CLR_PULSE(1'b0)) u_c (
        .clk(clk), .rst(rst_c), .data(data_c), .load(load_c),
        .busy(busy_c), .done(done_c), .sout(sout_c));
    para2ser_stream #(.WIDTH(8), .CLK_DIV(2), .MSB_FIRST(1'b1), .AUTO_UPDATE(1'b1),
                      .CLR_PULSE(1'b1)) u_d (
        .clk(clk), .rst(rst_d), .data(data_d), .load(load_d),
        .busy(busy_d), .done(done_d), .sout(sout_d));

    int         sel = 0;
    logic       ob_busy, ob_done;
    logic [3:0] ob_sout;
    always_comb begin
        ob_busy = busy_a; ob_done = done_a; ob_sout = sout_a;
        case (sel)
            1: begin ob_busy = busy_b; ob_done = done_b; ob_sout = sout_b; end
            2: begin ob_busy = busy_c; ob_done = done_c; ob_sout = sout_c; end
            3: begin ob_busy = busy_d; ob_done = done_d; ob_sout = sout_d; end
            default: ;
        endcase
    end

    int n_chk = 0;
    int n_fail = 0;

    // Observation record, cycles numbered from the last clear_obs.
    int          cyc, rises, dones, done_cyc, done_cyc2, busy_on_cyc, busy_off_cyc, busy_cnt;
    int          hi_run, hi_max, hi_cnt, clr_low_cnt, clr_low_first, first_rise_cyc, en_bad;
    logic [63:0] bits;
    logic        prev_clk, prev_busy;

    task automatic clear_obs();
        cyc = 0; rises = 0; dones = 0; done_cyc = -1; done_cyc2 = -1;
        busy_on_cyc = -1; busy_off_cyc = -1; busy_cnt = 0; hi_run = 0; hi_max = 0;
        hi_cnt = 0; clr_low_cnt = 0; clr_low_first = -1; first_rise_cyc = -1; en_bad = 0;
        bits = '0; prev_clk = 1'b0; prev_busy = 1'b0;
    endtask

    task automatic obs(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            if (ob_sout[3] && !prev_clk) begin
                rises++;
                bits = {bits[62:0], ob_sout[1]};
                if (first_rise_cyc < 0) first_rise_cyc = cyc;
            end
            if (ob_sout[3]) begin
                hi_cnt++; hi_run++;
                if (hi_run > hi_max) hi_max = hi_run;
            end else begin
                hi_run = 0;
            end
            if (ob_done) begin
                dones++;
                if (done_cyc < 0) done_cyc = cyc;
                else if (done_cyc2 < 0) done_cyc2 = cyc;
            end
            if (ob_busy) begin
                busy_cnt++;
                if (busy_on_cyc < 0) busy_on_cyc = cyc;
            end
            if (!ob_busy && prev_busy && busy_off_cyc < 0) busy_off_cyc = cyc;
            if (!ob_sout[2]) begin
                clr_low_cnt++;
                if (clr_low_first < 0) clr_low_first = cyc;
            end
            if (!ob_sout[0]) en_bad++;
            prev_clk  = ob_sout[3];
            prev_busy = ob_busy;
        end
    endtask

    task automatic test_reset();
        sel = 0;
        data_a = 8'hA5;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (ob_sout !== 4'b0101) begin n_fail++; $display("FAIL reset_sout: got %b want 0101", ob_sout); end
        n_chk++; if (ob_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", ob_busy); end
        n_chk++; if (ob_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ob_done); end
    endtask

    task automatic test_msb_first();
        sel = 0;
        @(negedge clk);
        rst_a = 1'b0;
        clear_obs();
        n_chk++; if (ob_busy !== 1'b0) begin n_fail++; $display("FAIL t1_busy_c0: got %b want 0", ob_busy); end
        obs(30);
        n_chk++; if (busy_on_cyc !== 1) begin n_fail++; $display("FAIL t1_busy_on: got %0d want 1", busy_on_cyc); end
        n_chk++; if (rises !== 8) begin n_fail++; $display("FAIL t1_rises: got %0d want 8", rises); end
        n_chk++; if (bits[7:0] !== 8'hA5) begin n_fail++; $display("FAIL t1_bits: got %h want a5", bits[7:0]); end
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL t1_dones: got %0d want 1", dones); end
        n_chk++; if (done_cyc !== 17) begin n_fail++; $display("FAIL t1_done_cyc: got %0d want 17", done_cyc); end
        n_chk++; if (busy_off_cyc !== 18) begin n_fail++; $display("FAIL t1_busy_off: got %0d want 18", busy_off_cyc); end
        n_chk++; if (en_bad !== 0) begin n_fail++; $display("FAIL t1_seg_en: got %0d low cycles want 0", en_bad); end
    endtask

    task automatic test_lsb_first();
        sel = 1;
        data_b = 8'hA5;
        @(negedge clk);
        rst_b = 1'b0;
        clear_obs();
        obs(25);
        n_chk++; if (bits[7:0] !== 8'hA5) begin n_fail++; $display("FAIL t2_bits_a5: got %h want a5", bits[7:0]); end
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL t2_dones_a5: got %0d want 1", dones); end
        data_b = 8'h01;
        clear_obs();
        obs(25);
        n_chk++; if (rises !== 8) begin n_fail++; $display("FAIL t2_rises_01: got %0d want 8", rises); end
        n_chk++; if (bits[7:0] !== 8'h80) begin n_fail++; $display("FAIL t2_bits_01: got %h want 80", bits[7:0]); end
        n_chk++; if (done_cyc !== 17) begin n_fail++; $display("FAIL t2_done_cyc: got %0d want 17", done_cyc); end
    endtask

    task automatic test_divider_manual();
        sel = 2;
        @(negedge clk);
        rst_c = 1'b0;
        obs(60);
        data_c = 8'hFF;
        load_c = 1'b1;
        clear_obs();
        obs(1);
        load_c = 1'b0;
        obs(59);
        n_chk++; if (busy_on_cyc !== 1) begin n_fail++; $display("FAIL t3_busy_on: got %0d want 1", busy_on_cyc); end
        n_chk++; if (rises !== 8) begin n_fail++; $display("FAIL t3_rises: got %0d want 8", rises); end
        n_chk++; if (bits[7:0] !== 8'hFF) begin n_fail++; $display("FAIL t3_bits: got %h want ff", bits[7:0]); end
        n_chk++; if (hi_cnt !== 24) begin n_fail++; $display("FAIL t3_hi_cnt: got %0d want 24", hi_cnt); end
        n_chk++; if (hi_max !== 3) begin n_fail++; $display("FAIL t3_hi_run: got %0d want 3", hi_max); end
        n_chk++; if (busy_cnt !== 49) begin n_fail++; $display("FAIL t3_busy_cnt: got %0d want 49", busy_cnt); end
        n_chk++; if (done_cyc !== 49) begin n_fail++; $display("FAIL t3_done_cyc: got %0d want 49", done_cyc); end
        data_c = 8'h0F;
        clear_obs();
        obs(60);
        n_chk++; if (dones !== 0) begin n_fail++; $display("FAIL t3_no_auto_done: got %0d want 0", dones); end
        n_chk++; if (busy_cnt !== 0) begin n_fail++; $display("FAIL t3_no_auto_busy: got %0d want 0", busy_cnt); end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        data_a = 8'h12;
        clear_obs();
        obs(5);
        data_a = 8'h34;
        obs(40);
        n_chk++; if (rises !== 16) begin n_fail++; $display("FAIL t4_rises: got %0d want 16", rises); end
        n_chk++; if (bits[15:0] !== 16'h1234) begin n_fail++; $display("FAIL t4_bits: got %h want 1234", bits[15:0]); end
        n_chk++; if (dones !== 2) begin n_fail++; $display("FAIL t4_dones: got %0d want 2", dones); end
        n_chk++; if (done_cyc !== 17) begin n_fail++; $display("FAIL t4_done1: got %0d want 17", done_cyc); end
        n_chk++; if (busy_off_cyc !== 18) begin n_fail++; $display("FAIL t4_idle: got %0d want 18", busy_off_cyc); end
        n_chk++; if (done_cyc2 !== 35) begin n_fail++; $display("FAIL t4_done2: got %0d want 35", done_cyc2); end
        n_chk++; if (busy_cnt !== 34) begin n_fail++; $display("FAIL t4_busy_cnt: got %0d want 34", busy_cnt); end
        // Value that returns to last_sent before IDLE must not re-send.
        data_a = 8'h56;
        clear_obs();
        obs(3);
        data_a = 8'h77;
        obs(3);
        data_a = 8'h56;
        obs(30);
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL t4_revert_dones: got %0d want 1", dones); end
        n_chk++; if (bits[7:0] !== 8'h56) begin n_fail++; $display("FAIL t4_revert_bits: got %h want 56", bits[7:0]); end
        data_a = 8'h9A;
        load_a = 1'b1;
        clear_obs();
        obs(1);
        load_a = 1'b0;
        obs(30);
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL t4_load_chg_dones: got %0d want 1", dones); end
        n_chk++; if (bits[7:0] !== 8'h9A) begin n_fail++; $display("FAIL t4_load_chg_bits: got %h want 9a", bits[7:0]); end
        load_a = 1'b1;
        clear_obs();
        obs(1);
        load_a = 1'b0;
        obs(3);
        load_a = 1'b1;
        obs(1);
        load_a = 1'b0;
        obs(40);
        n_chk++; if (dones !== 2) begin n_fail++; $display("FAIL t4_busy_load_dones: got %0d want 2", dones); end
        n_chk++; if (done_cyc2 !== 35) begin n_fail++; $display("FAIL t4_busy_load_done2: got %0d want 35", done_cyc2); end
    endtask

    task automatic test_clear_pulse();
        sel = 3;
        data_d = 8'hC3;
        @(negedge clk);
        rst_d = 1'b0;
        clear_obs();
        obs(50);
        n_chk++; if (clr_low_cnt !== 4) begin n_fail++; $display("FAIL t5_clr_cnt: got %0d want 4", clr_low_cnt); end
        n_chk++; if (clr_low_first !== 1) begin n_fail++; $display("FAIL t5_clr_first: got %0d want 1", clr_low_first); end
        n_chk++; if (first_rise_cyc !== 7) begin n_fail++; $display("FAIL t5_first_rise: got %0d want 7", first_rise_cyc); end
        n_chk++; if (rises !== 8) begin n_fail++; $display("FAIL t5_rises: got %0d want 8", rises); end
        n_chk++; if (bits[7:0] !== 8'hC3) begin n_fail++; $display("FAIL t5_bits: got %h want c3", bits[7:0]); end
        n_chk++; if (hi_cnt !== 16) begin n_fail++; $display("FAIL t5_hi_cnt: got %0d want 16", hi_cnt); end
        n_chk++; if (done_cyc !== 37) begin n_fail++; $display("FAIL t5_done_cyc: got %0d want 37", done_cyc); end
        n_chk++; if (busy_off_cyc !== 38) begin n_fail++; $display("FAIL t5_busy_off: got %0d want 38", busy_off_cyc); end
    endtask

    task automatic test_reset_mid_frame();
        sel = 0;
        data_a = 8'hE7;
        clear_obs();
        obs(7);
        n_chk++; if (rises !== 3) begin n_fail++; $display("FAIL t6_pre_rises: got %0d want 3", rises); end
        rst_a = 1'b1;
        #1;
        n_chk++; if (ob_sout !== 4'b0101) begin n_fail++; $display("FAIL t6_rst_sout: got %b want 0101", ob_sout); end
        n_chk++; if (ob_busy !== 1'b0) begin n_fail++; $display("FAIL t6_rst_busy: got %b want 0", ob_busy); end
        n_chk++; if (ob_done !== 1'b0) begin n_fail++; $display("FAIL t6_rst_done: got %b want 0", ob_done); end
        @(negedge clk);
        rst_a = 1'b0;
        clear_obs();
        obs(25);
        n_chk++; if (dones !== 1) begin n_fail++; $display("FAIL t6_dones: got %0d want 1", dones); end
        n_chk++; if (done_cyc !== 17) begin n_fail++; $display("FAIL t6_done_cyc: got %0d want 17", done_cyc); end
        n_chk++; if (rises !== 8) begin n_fail++; $display("FAIL t6_rises: got %0d want 8", rises); end
        n_chk++; if (bits[7:0] !== 8'hE7) begin n_fail++; $display("FAIL t6_bits: got %h want e7", bits[7:0]); end
    endtask

    initial begin
        clear_obs();
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_divider_manual();
        test_back_to_back();
        test_clear_pulse();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
